// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: opcodes, FSM states and
// the datapath select/fault codes driven by the controller.
package multicycle_control_fsm_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MDR = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b10;

    // Only the opcodes this controller knows how to sequence; anything else faults in ID.
    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OPC_LOAD, OPC_OP_IMM, OPC_STORE, OPC_OP,
            OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Counts cycles spent waiting on memory; expired flags the last permitted wait cycle.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    // Asserted during the TIMEOUT_CYCLES-th consecutive waiting cycle.
    assign expired = (count == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer: walks IF/ID/EX/MEM/WB, drives datapath enables and selects,
// handshakes with shared memory and counts retired instructions.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             halt_req,
    input  logic             bcond,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       alu_op_sel,
    output logic             pc_write,
    output logic [1:0]       pc_source,
    output logic             is_halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] retired_count
);

    state_t     state, state_next;
    logic [1:0] fault_next;
    logic       timer_clear, timer_enable, timer_expired;

    mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IF;
            fault         <= FAULT_NONE;
            retired_count <= '0;
        end else begin
            state <= state_next;
            fault <= fault_next;
            if (pc_write) begin
                retired_count <= retired_count + CNT_W'(1);
            end
        end
    end

    assign is_halted = (state == S_HALT);

    // The timer is held clear except while a request is outstanding, so it restarts on every IF/MEM entry.
    always_comb begin
        state_next   = state;
        fault_next   = fault;
        timer_clear  = 1'b1;
        timer_enable = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        i_or_d       = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = WB_ALU;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        alu_op_sel   = ALU_ADD;
        pc_write     = 1'b0;
        pc_source    = PC_PLUS4;

        if (reset) begin
            case (state)
                S_IF: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        state_next = S_ID;
                    end else if (timer_expired) begin
                        state_next = S_HALT;
                        fault_next = FAULT_TIMEOUT;
                    end else begin
                        timer_clear  = 1'b0;
                        timer_enable = 1'b1;
                    end
                end
                S_ID: begin
                    if (opcode == OPC_SYSTEM && halt_req) begin
                        state_next = S_HALT;
                    end else if (!is_legal_opcode(opcode)) begin
                        state_next = S_HALT;
                        fault_next = FAULT_ILLEGAL;
                    end else begin
                        state_next = S_EX;
                    end
                end
                S_EX: begin
                    case (opcode)
                        OPC_OP, OPC_OP_IMM: begin
                            alu_op_sel = ALU_FUNCT;
                            alu_src_b  = (opcode == OPC_OP_IMM);
                            state_next = S_WB;
                        end
                        OPC_LOAD, OPC_STORE: begin
                            alu_src_b  = 1'b1;
                            state_next = S_MEM;
                        end
                        OPC_BRANCH: begin
                            alu_op_sel = ALU_BRANCH;
                            pc_write   = 1'b1;
                            pc_source  = bcond ? PC_IMM : PC_PLUS4;
                            state_next = S_IF;
                        end
                        OPC_JAL, OPC_JALR: state_next = S_WB;
                        OPC_SYSTEM: begin
                            pc_write   = 1'b1;
                            state_next = S_IF;
                        end
                        default: begin
                            state_next = S_HALT;
                            fault_next = FAULT_ILLEGAL;
                        end
                    endcase
                end
                S_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = (opcode == OPC_LOAD);
                    mem_write = (opcode == OPC_STORE);
                    if (mem_ready) begin
                        if (opcode == OPC_LOAD) begin
                            state_next = S_WB;
                        end else begin
                            pc_write   = 1'b1;
                            state_next = S_IF;
                        end
                    end else if (timer_expired) begin
                        state_next = S_HALT;
                        fault_next = FAULT_TIMEOUT;
                    end else begin
                        timer_clear  = 1'b0;
                        timer_enable = 1'b1;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_IF;
                    case (opcode)
                        OPC_LOAD: wb_sel = WB_MDR;
                        OPC_JAL: begin
                            wb_sel    = WB_PC4;
                            pc_source = PC_IMM;
                        end
                        OPC_JALR: begin
                            wb_sel    = WB_PC4;
                            pc_source = PC_ALU;
                            alu_src_b = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_HALT:  state_next = S_HALT;
                default: state_next = S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: driver pushes each directed vector's index, monitor pops on every
// retirement or halt entry and compares against the hand-computed table row.
module tb_multicycle_control_fsm;
    import multicycle_control_fsm_pkg::*;

    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 255;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [6:0]       opcode = OPC_OP;
    logic             halt_req = 1'b0;
    logic             bcond = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_read, mem_write, i_or_d, ir_write, reg_write;
    logic [1:0]       wb_sel, alu_op_sel, pc_source, fault;
    logic             alu_src_a, alu_src_b, pc_write, is_halted;
    logic [CNT_W-1:0] retired_count;

    multicycle_control_fsm #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .halt_req(halt_req), .bcond(bcond),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op_sel(alu_op_sel), .pc_write(pc_write),
        .pc_source(pc_source), .is_halted(is_halted), .fault(fault),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [6:0] op;
        logic       bc, hr;
        int         fdly, mdly, lat;
        logic       pcw, rw, halt, mrd, mwr, iod, srcb;
        logic [1:0] wb, pcs, alu, flt;
        logic [2:0] cnt;
        int         post;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];
    int   expq [$];

    // post: 0 none, 1 quiet halt check then reset, 2 reset, 3 reset then mid-wait reset
    initial begin
        //          op          bc  hr  fd  md  lat pcw  rw  hlt mrd mwr iod sb  wb     pcs    alu    flt    cnt post
        vecs[0]  = '{OPC_OP_IMM, 0, 0,  0,  0,   4, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 0};
        vecs[1]  = '{OPC_OP,     0, 1,  0,  0,   4, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd1, 0};
        vecs[2]  = '{OPC_LOAD,   0, 0,  0,  3,   8, 1, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'd2, 0};
        vecs[3]  = '{OPC_BRANCH, 1, 0,  0,  0,   3, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'd3, 0};
        vecs[4]  = '{OPC_BRANCH, 0, 0,  0,  0,   3, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 3'd4, 0};
        vecs[5]  = '{OPC_JALR,   0, 0,  0,  0,   4, 1, 1, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 3'd5, 0};
        vecs[6]  = '{OPC_STORE,  0, 0,  2,  1,   7, 1, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd6, 0};
        vecs[7]  = '{OPC_JAL,    0, 0,  1,  0,   5, 1, 1, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 3'd7, 0};
        vecs[8]  = '{OPC_SYSTEM, 0, 0,  0,  0,   3, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 0};
        vecs[9]  = '{OPC_OP_IMM, 0, 0,  2,  0,   6, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd1, 0};
        vecs[10] = '{OPC_SYSTEM, 0, 1,  0,  0,   3, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd2, 1};
        vecs[11] = '{7'b0110111, 0, 0,  0,  0,   3, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b10, 3'd0, 2};
        vecs[12] = '{OPC_OP,     0, 0, 1000, 0, 256, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'd0, 3};
        vecs[13] = '{OPC_OP,     0, 0,  0,  0,   4, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 0};
    end

    task automatic checkOutput(input string what, input int idx, input logic [31:0] act,
                               input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s (vec %0d): got %0h, expected %0h", what, idx, act, exp);
        end
    endtask

    // Memory model plus sequencing: answers each request after the row's wait count and
    // checks the request signature on every cycle it is held.
    task automatic applyStimulus(input int i);
        int   acc = 0;
        int   wcnt = 0;
        int   dly;
        bit   done = 0;
        logic [2:0] sig;
        opcode   = vecs[i].op;
        bcond    = vecs[i].bc;
        halt_req = vecs[i].hr;
        expq.push_back(i);
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                dly = (acc == 0) ? vecs[i].fdly : vecs[i].mdly;
                sig = (acc == 0) ? 3'b100 : ((vecs[i].op == OPC_STORE) ? 3'b011 : 3'b101);
                checkOutput("mem_request", i, {29'd0, mem_read, mem_write, i_or_d}, {29'd0, sig});
                if (wcnt >= dly) begin
                    mem_ready = 1'b1;
                    acc++;
                    wcnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            if (pc_write || is_halted) done = 1;
        end
        if (!done) checkOutput("retire_timeout", i, 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checkOutput("rst_mem_read", -1, {31'd0, mem_read}, 32'd0);
        checkOutput("rst_ir_write", -1, {31'd0, ir_write}, 32'd0);
        checkOutput("rst_pc_write", -1, {31'd0, pc_write}, 32'd0);
        checkOutput("rst_is_halted", -1, {31'd0, is_halted}, 32'd0);
        checkOutput("rst_fault", -1, {30'd0, fault}, 32'd0);
        checkOutput("rst_retired", -1, {29'd0, retired_count}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Monitor: one scoreboard entry per retirement pulse or halt entry.
    initial begin
        int   start = 0;
        logic prev_h = 1'b0;
        int   idx;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                start  = cyc + 1;
                prev_h = 1'b0;
            end else begin
                if (pc_write || (is_halted && !prev_h)) begin
                    if (expq.size() == 0) begin
                        checkOutput("unexpected_event", -1, {31'd0, pc_write}, 32'd0);
                    end else begin
                        idx = expq.pop_front();
                        checkOutput("latency", idx, cyc - start + 1, vecs[idx].lat);
                        checkOutput("pc_write", idx, {31'd0, pc_write}, {31'd0, vecs[idx].pcw});
                        checkOutput("reg_write", idx, {31'd0, reg_write}, {31'd0, vecs[idx].rw});
                        checkOutput("is_halted", idx, {31'd0, is_halted}, {31'd0, vecs[idx].halt});
                        checkOutput("mem_read", idx, {31'd0, mem_read}, {31'd0, vecs[idx].mrd});
                        checkOutput("mem_write", idx, {31'd0, mem_write}, {31'd0, vecs[idx].mwr});
                        checkOutput("i_or_d", idx, {31'd0, i_or_d}, {31'd0, vecs[idx].iod});
                        checkOutput("alu_src_b", idx, {31'd0, alu_src_b}, {31'd0, vecs[idx].srcb});
                        checkOutput("wb_sel", idx, {30'd0, wb_sel}, {30'd0, vecs[idx].wb});
                        checkOutput("pc_source", idx, {30'd0, pc_source}, {30'd0, vecs[idx].pcs});
                        checkOutput("alu_op_sel", idx, {30'd0, alu_op_sel}, {30'd0, vecs[idx].alu});
                        checkOutput("fault", idx, {30'd0, fault}, {30'd0, vecs[idx].flt});
                        checkOutput("retired_count", idx, {29'd0, retired_count}, {29'd0, vecs[idx].cnt});
                    end
                    start = cyc + 1;
                end
                prev_h = is_halted;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetDut();
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(i);
            if (vecs[i].post == 1) begin
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    #1;
                    checkOutput("halt_quiet_req", i, {30'd0, mem_read, mem_write}, 32'd0);
                    checkOutput("halt_quiet_pcw", i, {30'd0, pc_write, reg_write}, 32'd0);
                    checkOutput("halt_quiet_cnt", i, {29'd0, retired_count}, 32'd2);
                end
                resetDut();
            end else if (vecs[i].post == 2) begin
                resetDut();
            end else if (vecs[i].post == 3) begin
                resetDut();
                mem_ready = 1'b0;
                repeat (20) @(negedge clk);
                #1 checkOutput("midwait_req", i, {30'd0, mem_read, i_or_d}, 32'd2);
                resetDut();
                #1;
                checkOutput("post_reset_req", i, {30'd0, mem_read, i_or_d}, 32'd2);
                checkOutput("post_reset_halt", i, {31'd0, is_halted}, 32'd0);
            end
        end
        repeat (3) @(negedge clk);
        checkOutput("queue_drained", -1, expq.size(), 32'd0);
        checkOutput("final_retired", -1, {29'd0, retired_count}, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
